// File: rtl/timer_pkg.sv
// Shared constants, BCD digit type and digit helpers for the play timer.
// Pure declarations and functions; no clocked logic.
// Configuration macro consumed by users of this package: PLAY_TIMER_DOWN_EN.
package timer_pkg;

    localparam int SEC_MAX = 59;
    localparam int BCD_W   = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    // Limit a BCD digit to lim (invalid codes collapse to the limit).
    function automatic bcd_t bcd_clamp(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

    // Binary seconds 0..59 to {tens, units} BCD.
    function automatic logic [2*BCD_W-1:0] sec_to_bcd(input logic [6:0] s);
        bcd_t       tens;
        logic [6:0] rem;
        tens = '0;
        rem  = s;
        for (int i = 0; i < 5; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, BCD_W'(rem)};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Purpose: divides clk into one-second events, counting 0..CLK_DIV-1 while enabled.
// Latency: tick_o is combinational, high during the cycle whose edge wraps the counter.
// Backpressure: en_i low freezes the phase; clr_i forces phase 0 and masks tick_o.
module timer_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == CW'(CLK_DIV - 1));

    // Next phase: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    // Phase register; reset aborts any second in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/play_timer.sv
// Purpose: BCD mm:ss play timer, up count with wrap, optional down count (macro PLAY_TIMER_DOWN_EN).
// Latency: time, tick, wrap and done all update on the edge that completes a second.
// Backpressure: count low stalls the prescaler; load overrides any tick in the same cycle.
module play_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 2,
    parameter int CLK_DIV    = 50_000_000,
    parameter int STEP_W     = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      count,
    input  logic [STEP_W-1:0]         adder,
    input  logic                      dir,
    input  logic                      load,
    input  logic [8+4*MIN_DIGITS-1:0] load_value,
    output logic [3:0]                seconds0,
    output logic [3:0]                seconds1,
    output logic [4*MIN_DIGITS-1:0]   minutes,
    output logic                      tick,
    output logic                      wrap,
    output logic                      done,
    output logic                      at_zero
);

    logic                  pre_tick;
    bcd_t                  s0_q, s0_d, s1_q, s1_d;
    bcd_t [MIN_DIGITS-1:0] min_q, min_d, min_inc;
    logic                  tick_q, tick_d, wrap_q, wrap_d;
    logic [6:0]            sec_cur, step, sec_sum, sec_up;
    logic                  carry_up, c_up;

    timer_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en_i   (count),
        .clr_i  (load),
        .tick_o (pre_tick)
    );

    assign at_zero = (s0_q == '0) && (s1_q == '0) && (min_q == '0);

    // Up path: seconds sum with carry rippled through the minute digits.
    always_comb begin
        sec_cur  = 7'(s1_q) * 7'd10 + 7'(s0_q);
        step     = (32'(adder) > SEC_MAX) ? 7'(SEC_MAX) : 7'(adder);
        sec_sum  = sec_cur + step;
        carry_up = (sec_sum >= 7'd60);
        sec_up   = carry_up ? sec_sum - 7'd60 : sec_sum;
        min_inc  = min_q;
        c_up     = carry_up;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (c_up) begin
                if (min_q[i] >= 4'd9) begin
                    min_inc[i] = '0;
                end else begin
                    min_inc[i] = min_q[i] + 4'd1;
                    c_up       = 1'b0;
                end
            end
        end
    end

`ifdef PLAY_TIMER_DOWN_EN
    bcd_t [MIN_DIGITS-1:0] min_dec;
    logic [6:0]            sec_dn;
    logic                  borrow, b_dn;
    logic                  done_q, done_d;

    // Down path: seconds difference with borrow rippled through the minute digits;
    // a borrow out of the top digit means the step exceeds the remaining time.
    always_comb begin
        borrow  = (sec_cur < step);
        sec_dn  = borrow ? sec_cur + 7'd60 - step : sec_cur - step;
        min_dec = min_q;
        b_dn    = borrow;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (b_dn) begin
                if (min_q[i] == '0) begin
                    min_dec[i] = 4'd9;
                end else begin
                    min_dec[i] = min_q[i] - 4'd1;
                    b_dn       = 1'b0;
                end
            end
        end
    end
`else
    logic dir_unused;
    assign dir_unused = dir;
`endif

    // Next time and event pulses: load first, then the second tick.
    always_comb begin
        s0_d   = s0_q;
        s1_d   = s1_q;
        min_d  = min_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
`ifdef PLAY_TIMER_DOWN_EN
        done_d = 1'b0;
`endif
        if (load) begin
            s0_d = bcd_clamp(load_value[3:0], 4'd9);
            s1_d = bcd_clamp(load_value[7:4], 4'd5);
            for (int i = 0; i < MIN_DIGITS; i++) begin
                min_d[i] = bcd_clamp(load_value[8+4*i +: 4], 4'd9);
            end
        end else if (pre_tick) begin
            tick_d = 1'b1;
`ifdef PLAY_TIMER_DOWN_EN
            if (dir) begin
                if (b_dn) begin
                    s0_d  = '0;
                    s1_d  = '0;
                    min_d = '0;
                end else begin
                    {s1_d, s0_d} = sec_to_bcd(sec_dn);
                    min_d        = min_dec;
                end
                // Only the transition into 00:00 counts; sitting at zero stays quiet.
                done_d = !at_zero && (s0_d == '0) && (s1_d == '0) && (min_d == '0);
            end else begin
                {s1_d, s0_d} = sec_to_bcd(sec_up);
                min_d        = min_inc;
                wrap_d       = c_up;
            end
`else
            {s1_d, s0_d} = sec_to_bcd(sec_up);
            min_d        = min_inc;
            wrap_d       = c_up;
`endif
        end
    end

    // Time and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_q   <= '0;
            s1_q   <= '0;
            min_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            min_q  <= min_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef PLAY_TIMER_DOWN_EN
    // Done pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end
    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    assign seconds0 = s0_q;
    assign seconds1 = s1_q;
    assign minutes  = min_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;

endmodule
